// File: rtl/systolic_result_drain.sv
// Result-drain stage: snapshots the PE accumulators on the rising edge of compute_done, then
// streams them out in row-major order, requantized with round-half-up and saturation.
module systolic_result_drain #(
    parameter int unsigned num_row       = 3,
    parameter int unsigned num_col       = 3,
    parameter int unsigned acc_word_size = 16,
    parameter int unsigned out_word_size = 8
) (
    input  logic                                           clk,
    input  logic                                           reset,
    input  logic                                           compute_done,
    input  logic [0:acc_word_size*num_row*num_col-1]       pe_register_vals,
    input  logic [3:0]                                     shift,
    output logic                                           out_valid,
    input  logic                                           out_ready,
    output logic [out_word_size-1:0]                       out_data,
    output logic [(num_row > 1 ? $clog2(num_row) : 1)-1:0] out_row,
    output logic [(num_col > 1 ? $clog2(num_col) : 1)-1:0] out_col,
    output logic                                           out_last,
    output logic                                           busy,
    output logic                                           overrun
);

    localparam int unsigned TotalW = acc_word_size * num_row * num_col;
    localparam int unsigned RowW   = num_row > 1 ? $clog2(num_row) : 1;
    localparam int unsigned ColW   = num_col > 1 ? $clog2(num_col) : 1;
    localparam int unsigned AccW1  = acc_word_size + 1;

    localparam logic [RowW-1:0] LastRow  = RowW'(num_row - 1);
    localparam logic [ColW-1:0] LastCol  = ColW'(num_col - 1);
    localparam logic [3:0]      MaxShift = 4'(acc_word_size - 1 > 15 ? 15 : acc_word_size - 1);

    localparam logic signed [acc_word_size:0] OutMax = AccW1'(2 ** (out_word_size - 1) - 1);
    localparam logic signed [acc_word_size:0] OutMin = ~OutMax;
    localparam logic [out_word_size-1:0] OutMaxW = {1'b0, {(out_word_size - 1){1'b1}}};
    localparam logic [out_word_size-1:0] OutMinW = {1'b1, {(out_word_size - 1){1'b0}}};

    typedef enum logic [0:0] {StIdle, StStream} state_e;

    state_e                state_q, state_d;
    logic                  done_q;
    logic [0:TotalW-1]     snap_q, snap_d;
    logic [3:0]            shift_q, shift_d;
    logic [RowW-1:0]       row_q, row_d;
    logic [ColW-1:0]       col_q, col_d;
    logic                  overrun_q, overrun_d;

    logic                  done_edge;
    logic                  handshake;
    logic                  at_last;
    int unsigned           idx;
    logic [acc_word_size-1:0]        word;
    logic signed [acc_word_size:0]   ext, rnd, sum, shifted;

    assign done_edge = compute_done & ~done_q;
    assign at_last   = (state_q == StStream) && (row_q == LastRow) && (col_q == LastCol);
    assign handshake = out_valid & out_ready;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            done_q    <= 1'b0;
            snap_q    <= '0;
            shift_q   <= '0;
            row_q     <= '0;
            col_q     <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            done_q    <= compute_done;
            snap_q    <= snap_d;
            shift_q   <= shift_d;
            row_q     <= row_d;
            col_q     <= col_d;
            overrun_q <= overrun_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (done_edge) state_d = StStream;
            StStream: if (handshake && at_last) state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Datapath next-state: capture, index walk, sticky overrun
    always_comb begin
        snap_d    = snap_q;
        shift_d   = shift_q;
        row_d     = row_q;
        col_d     = col_q;
        overrun_d = overrun_q | (done_edge & (state_q == StStream));
        if (state_q == StIdle && done_edge) begin
            snap_d  = pe_register_vals;
            shift_d = (shift > MaxShift) ? MaxShift : shift;
            row_d   = '0;
            col_d   = '0;
        end else if (handshake) begin
            if (col_q == LastCol) begin
                col_d = '0;
                row_d = at_last ? '0 : row_q + RowW'(1);
            end else begin
                col_d = col_q + ColW'(1);
            end
        end
    end

    // Requantization; one extra bit keeps the rounding add from overflowing
    always_comb begin
        idx  = 32'(row_q) * num_col + 32'(col_q);
        word = snap_q[acc_word_size*idx +: acc_word_size];
        ext  = $signed({word[acc_word_size-1], word});
        rnd  = '0;
        if (shift_q != 4'd0) rnd = AccW1'(1) << (shift_q - 4'd1);
        sum     = ext + rnd;
        shifted = sum >>> shift_q;
    end

    // Output logic
    always_comb begin
        out_valid = (state_q == StStream);
        busy      = (state_q == StStream);
        out_last  = at_last;
        out_row   = row_q;
        out_col   = col_q;
        overrun   = overrun_q;
        if (shifted > OutMax)      out_data = OutMaxW;
        else if (shifted < OutMin) out_data = OutMinW;
        else                       out_data = shifted[out_word_size-1:0];
    end

endmodule

// File: tb/tb_systolic_result_drain.sv
// Directed bench for systolic_result_drain: ramp, backpressure, snapshot isolation,
// requantization corner values, overrun and mid-stream reset.
module tb_systolic_result_drain;

    localparam int NR = 3;
    localparam int NC = 3;
    localparam int AW = 16;
    localparam int OW = 8;
    localparam int NP = NR * NC;

    logic            clk = 1'b0;
    logic            reset;
    logic            compute_done;
    logic [0:AW*NP-1] pe;
    logic [3:0]      shift;
    logic            out_valid;
    logic            out_ready;
    logic [OW-1:0]   out_data;
    logic [1:0]      out_row;
    logic [1:0]      out_col;
    logic            out_last;
    logic            busy;
    logic            overrun;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    systolic_result_drain #(
        .num_row      (NR),
        .num_col      (NC),
        .acc_word_size(AW),
        .out_word_size(OW)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .compute_done    (compute_done),
        .pe_register_vals(pe),
        .shift           (shift),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_data        (out_data),
        .out_row         (out_row),
        .out_col         (out_col),
        .out_last        (out_last),
        .busy            (busy),
        .overrun         (overrun)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_pe(input int k, input int v);
        pe[AW*k +: AW] = 16'(v);
    endtask

    task automatic set_ramp(input int base);
        for (int k = 0; k < NP; k++) set_pe(k, base + k);
    endtask

    // Consume one full stream of words base..base+8 (shift 0).
    // mode 0: ready high, 1: ready 1,0,0,1 pattern, 2: scramble pe every cycle,
    // 3: drop and re-raise compute_done mid-stream with new pe values.
    task automatic drain_stream(input int base, input int mode, input string tag);
        int n   = 0;
        int cyc = 0;
        while (n < NP && cyc < 80) begin
            out_ready = (mode == 1) ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
            if (mode == 2) for (int k = 0; k < NP; k++) set_pe(k, int'($urandom_range(200, 900)));
            if (mode == 3 && cyc == 2) compute_done = 1'b0;
            if (mode == 3 && cyc == 4) begin
                compute_done = 1'b1;
                set_ramp(base + 50);
            end
            #1;
            chk({tag, " valid"}, out_valid, 1);
            chk({tag, " data"}, $signed(out_data), base + n);
            chk({tag, " row"}, out_row, n / NC);
            chk({tag, " col"}, out_col, n % NC);
            chk({tag, " last"}, out_last, (n == NP - 1) ? 1 : 0);
            if (out_valid && out_ready) n++;
            tick();
            cyc++;
        end
        chk({tag, " count"}, n, NP);
        chk({tag, " valid_after"}, out_valid, 0);
        chk({tag, " busy_after"}, busy, 0);
    endtask

    task automatic rq(input int v, input int sh, input int exp, input string tag);
        set_pe(0, v);
        shift        = 4'(sh);
        out_ready    = 1'b0;
        compute_done = 1'b1;
        tick();
        shift = 4'd0;  // must not matter after capture
        #1;
        chk({tag, " data"}, $signed(out_data), exp);
        out_ready = 1'b1;
        for (int i = 0; i < 20 && out_valid; i++) tick();
        chk({tag, " drained"}, out_valid, 0);
        compute_done = 1'b0;
        tick();
        tick();
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " valid"}, out_valid, 0);
        chk({tag, " busy"}, busy, 0);
        chk({tag, " last"}, out_last, 0);
        chk({tag, " overrun"}, overrun, 0);
        chk({tag, " row"}, out_row, 0);
        chk({tag, " col"}, out_col, 0);
        chk({tag, " data"}, $signed(out_data), 0);
    endtask

    initial begin
        reset        = 1'b1;
        compute_done = 1'b0;
        out_ready    = 1'b0;
        shift        = 4'd0;
        pe           = '0;
        tick();
        tick();
        chk_reset_vals("reset");
        reset = 1'b0;
        tick();

        // Ramp with ready held high
        set_ramp(0);
        out_ready    = 1'b1;
        compute_done = 1'b1;
        tick();
        drain_stream(0, 0, "ramp");
        chk("ramp overrun", overrun, 0);
        compute_done = 1'b0;
        tick();
        tick();

        // Backpressure
        set_ramp(10);
        compute_done = 1'b1;
        tick();
        drain_stream(10, 1, "bp");
        compute_done = 1'b0;
        tick();
        tick();

        // Snapshot isolation
        set_ramp(20);
        compute_done = 1'b1;
        tick();
        drain_stream(20, 2, "iso");
        compute_done = 1'b0;
        tick();
        tick();

        // Requantization
        rq(300, 1, 127, "rq300");
        rq(-300, 2, -75, "rqm300");
        rq(5, 1, 3, "rq5");
        rq(-5, 1, -2, "rqm5");
        rq(32767, 0, 127, "rqmax");
        rq(16384, 15, 1, "rqsh15");

        // Overrun: edge during stream is ignored but flagged
        set_ramp(30);
        compute_done = 1'b1;
        tick();
        drain_stream(30, 3, "ovr");
        chk("ovr overrun", overrun, 1);
        tick();
        tick();
        chk("ovr overrun held", overrun, 1);
        chk("ovr no restart", out_valid, 0);

        // Reset mid-stream with compute_done held high
        set_ramp(40);
        compute_done = 1'b0;
        tick();
        compute_done = 1'b1;
        out_ready    = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) tick();
        chk("rst mid row", out_row, 1);
        chk("rst mid col", out_col, 2);
        reset = 1'b1;
        set_ramp(60);
        tick();
        chk_reset_vals("rst");
        reset = 1'b0;
        tick();
        drain_stream(60, 0, "rst restart");
        chk("rst restart overrun", overrun, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/systolic_result_drain.md
# systolic_result_drain

Result-drain stage for the systolic array. It watches the array's `compute_done` level and, on its rising edge, snapshots the flat `pe_register_vals` accumulator bus. It then streams the PE results out one word per valid/ready handshake in row-major order, requantizing each signed accumulator to the output word size with rounding and saturation. It sits between the array and the downstream writeback or next-layer feeder.

## Interface
- `num_row`, default 3: PE rows.
- `num_col`, default 3: PE columns.
- `acc_word_size`, default 16: PE accumulator width, signed two's complement.
- `out_word_size`, default 8: streamed result width, signed.
- `clk`  in  1: clock, all state updates on its rising edge.
- `reset`  in  1: reset, synchronous, active-high.
- `compute_done`  in  1: array done level; stays high until the array is reset.
- `pe_register_vals`  in  `[0 : acc_word_size*num_row*num_col-1]`: element (r,c) is at `[acc_word_size*(r*num_col+c) : acc_word_size*(r*num_col+c+1)-1]`, big-endian indexed.
- `shift`  in  4: requant right-shift amount, sampled at capture.
- `out_valid`  out  1: result word available.
- `out_ready`  in  1: downstream accepts.
- `out_data`  out  `out_word_size`: requantized result.
- `out_row`  out  `clog2(num_row)` (min 1): row of the current word.
- `out_col`  out  `clog2(num_col)` (min 1): column of the current word.
- `out_last`  out  1: current word is (num_row-1, num_col-1).
- `busy`  out  1: high in STREAM.
- `overrun`  out  1: sticky; a done edge arrived while busy.

## Operation
- Edge detect: `done_q` is `compute_done` registered. An edge is `compute_done & ~done_q`.
- States: IDLE and STREAM.
- IDLE → STREAM on an edge:
  - Capture the entire `pe_register_vals` into the snapshot register.
  - Latch `shift` into `shift_q`; values above `acc_word_size-1` clamp to `acc_word_size-1`.
  - Set `idx` to 0 and `row`/`col` to 0.
- STREAM behaviour:
  - `out_valid`=1.
  - `out_data` = requant(snapshot[idx]).
  - A handshake is `out_valid & out_ready`. On a handshake, `col` increments; at `num_col-1` it wraps to 0 and `row` increments.
  - A handshake while `out_last`=1 returns to IDLE.
- Requant:
  - Sign-extend to `acc_word_size+1` bits.
  - Add `1<<(shift_q-1)` when `shift_q`>0 (round half up).
  - Arithmetic right shift by `shift_q`.
  - Saturate to [-2^(out_word_size-1), 2^(out_word_size-1)-1].
- `out_last` = STREAM & row==num_row-1 & col==num_col-1.
- Edge while in STREAM, including the cycle of the final handshake:
  - The edge is ignored; snapshot and stream are unaffected.
  - `overrun` is set to 1 and stays set until reset.
- The snapshot is only written on capture. Changes on `pe_register_vals` during STREAM have no effect.

## Timing
- Reset values: state IDLE, `done_q`=0, `out_valid`=0, `out_last`=0, `busy`=0, `overrun`=0, `row`=`col`=0, snapshot=0, `shift_q`=0, `out_data`=0.
- Latency: an edge is seen at clock edge k, and `out_valid`=1 in the cycle after edge k with word (0,0).
- Throughput: with `out_ready` held high, all num_row*num_col words transfer in consecutive cycles. `out_valid` drops in the cycle after the last handshake.
- Stability: while `out_valid`=1 and `out_ready`=0, `out_data`, `out_row`, `out_col` and `out_last` hold stable.
- `out_valid` never deasserts without a handshake, except on reset.
- Reset mid-stream:
  - The stream is abandoned and all outputs return to reset values after the reset edge.
  - If `compute_done` is still high after reset, the `done_q`=0 rule makes it count as an edge and a fresh capture occurs.
- Combinational paths: `out_data` is combinational from the snapshot, `idx` and `shift_q` only. There is no path from `out_ready` to `out_valid`.

## Test plan
- Ramp, `shift`=0, `out_ready`=1:
  - Stimulus: PE (r,c)=r*3+c, raise `compute_done`.
  - Response: 9 consecutive words 0..8; (row,col) goes (0,0)…(2,2); `out_last` only on word 8; `busy` low after.
- Backpressure:
  - Stimulus: toggle `out_ready` 1,0,0,1,…
  - Response: same 9 words in order, none dropped or duplicated, outputs stable while stalled.
- Requant:
  - PE values 300 / -300 / 5 / -5 / 32767 with `shift` 1 / 2 / 1 / 1 / 0.
  - Response: `out_data` 127 / -75 / 3 / -2 / 127.
  - `shift`=15 on value 16384: response 1.
- Overrun:
  - Stimulus: drop and re-raise `compute_done` mid-stream with changed `pe_register_vals`.
  - Response: original 9 words delivered unchanged and `overrun`=1 held.
- Reset:
  - Stimulus: reset after word 4 while `compute_done` stays high.
  - Response: outputs go to reset values, then a new capture restarts at word (0,0) with `overrun`=0.
- Snapshot isolation:
  - Stimulus: change `pe_register_vals` every cycle during STREAM.
  - Response: streamed data equals the values present at the capture edge.
